// File: rtl/scanline_zfill.sv
// scanline_zfill: walks one span per handshake from left to right and writes
// colour and depth to the frame/z memories.
// Build option SCANLINE_ZFILL_ZTEST_EN: when defined, each pixel's z-buffer
// entry is read and compared first, and only nearer pixels are written. When
// undefined, every clipped pixel is written at one pixel per cycle.
//
// state  | meaning
// IDLE   | span_ready high, waiting for a span
// SETUP  | clip right edge, reject empty spans, form the start address
// RD     | z-buffer read strobe for the current pixel (depth test build)
// WAIT   | waiting for the z read response (depth test build)
// TEST   | depth compare on the captured value (depth test build)
// WR     | write request held until wr_ready
// NEXT   | step to the next pixel or finish (depth test build)
// FIN    | done pulse with pix_written, then back to IDLE
module scanline_zfill #(
   parameter int WIDTH   = 640,
   parameter int HEIGHT  = 480,
   parameter int ADDR_W  = 19,
   parameter int COLOR_W = 8,
   parameter int Z_W     = 8,
   parameter int ZF      = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 span_valid,
   output logic                 span_ready,
   input  logic [15:0]          span_y,
   input  logic [15:0]          span_xl,
   input  logic [15:0]          span_xr,
   input  logic [Z_W+ZF-1:0]    span_z0,
   input  logic [Z_W+ZF:0]      span_dz,
   input  logic [COLOR_W-1:0]   span_color,
   output logic                 zrd_en,
   output logic [ADDR_W-1:0]    zrd_addr,
   input  logic                 zrd_valid,
   input  logic [Z_W-1:0]       zrd_data,
   output logic                 wr_en,
   input  logic                 wr_ready,
   output logic [ADDR_W-1:0]    wr_addr,
   output logic [COLOR_W-1:0]   wr_color,
   output logic [Z_W-1:0]       wr_z,
   output logic                 done,
   output logic [15:0]          pix_written
);

   localparam int ZA_W = Z_W + ZF;
   localparam logic [15:0] X_MAX   = 16'(WIDTH - 1);
   localparam logic [15:0] Y_LIM   = 16'(HEIGHT);
   localparam logic [31:0] WIDTH_W = 32'(WIDTH);

`ifdef SCANLINE_ZFILL_ZTEST_EN
   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_RD, S_WAIT, S_TEST, S_WR, S_NEXT, S_FIN
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE, S_SETUP, S_WR, S_FIN
   } state_t;
`endif

   state_t               state_q;
   logic [15:0]          y_q;
   logic [15:0]          x_q;
   logic [15:0]          xr_q;
   logic [ZA_W-1:0]      zacc_q;
   logic [ZA_W:0]        dz_q;
   logic [COLOR_W-1:0]   color_q;
   logic [ADDR_W-1:0]    addr_q;
   logic [15:0]          cnt_q;

   logic [15:0]          xr_clip;
   logic                 span_empty;
   logic                 x_last;
   logic [ADDR_W-1:0]    start_addr;
   logic [ZA_W+1:0]      zsum;
   logic [ZA_W-1:0]      zacc_d;
   logic [Z_W-1:0]       znew;

   // Right edge clipped to the screen; addresses then never run past the row.
   assign xr_clip    = (xr_q > X_MAX) ? X_MAX : xr_q;
   assign span_empty = (y_q >= Y_LIM) || (x_q > xr_clip);
   assign x_last     = (x_q == xr_clip);
   assign start_addr = ADDR_W'({16'd0, y_q} * WIDTH_W + {16'd0, x_q});

   // Sum has one guard bit above the accumulator and a sign bit on top:
   // sign set means it went below zero, guard set means it overflowed.
   assign zsum   = {2'b00, zacc_q} + {dz_q[ZA_W], dz_q};
   assign zacc_d = zsum[ZA_W+1] ? '0 : (zsum[ZA_W] ? '1 : zsum[ZA_W-1:0]);
   assign znew   = zacc_q[ZA_W-1:ZF];

`ifdef SCANLINE_ZFILL_ZTEST_EN
   logic [Z_W-1:0]       zst_q;

   // Span sequencer with depth test; all outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         span_ready  <= 1'b1;
         zrd_en      <= 1'b0;
         zrd_addr    <= '0;
         wr_en       <= 1'b0;
         wr_addr     <= '0;
         wr_color    <= '0;
         wr_z        <= '0;
         done        <= 1'b0;
         pix_written <= '0;
         y_q         <= '0;
         x_q         <= '0;
         xr_q        <= '0;
         zacc_q      <= '0;
         dz_q        <= '0;
         color_q     <= '0;
         addr_q      <= '0;
         cnt_q       <= '0;
         zst_q       <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (span_valid) begin
                  span_ready <= 1'b0;
                  y_q        <= span_y;
                  x_q        <= span_xl;
                  xr_q       <= span_xr;
                  zacc_q     <= span_z0;
                  dz_q       <= span_dz;
                  color_q    <= span_color;
                  state_q    <= S_SETUP;
               end
            end
            S_SETUP: begin
               cnt_q  <= '0;
               addr_q <= start_addr;
               if (span_empty) begin
                  done        <= 1'b1;
                  pix_written <= '0;
                  state_q     <= S_FIN;
               end else begin
                  zrd_en   <= 1'b1;
                  zrd_addr <= start_addr;
                  state_q  <= S_RD;
               end
            end
            S_RD: begin
               zrd_en  <= 1'b0;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (zrd_valid) begin
                  zst_q   <= zrd_data;
                  state_q <= S_TEST;
               end
            end
            S_TEST: begin
               if (znew < zst_q) begin
                  wr_en    <= 1'b1;
                  wr_addr  <= addr_q;
                  wr_color <= color_q;
                  wr_z     <= znew;
                  state_q  <= S_WR;
               end else begin
                  state_q <= S_NEXT;
               end
            end
            S_WR: begin
               if (wr_ready) begin
                  wr_en   <= 1'b0;
                  cnt_q   <= cnt_q + 16'd1;
                  state_q <= S_NEXT;
               end
            end
            S_NEXT: begin
               if (x_last) begin
                  done        <= 1'b1;
                  pix_written <= cnt_q;
                  state_q     <= S_FIN;
               end else begin
                  x_q      <= x_q + 16'd1;
                  addr_q   <= addr_q + ADDR_W'(1);
                  zacc_q   <= zacc_d;
                  zrd_en   <= 1'b1;
                  zrd_addr <= addr_q + ADDR_W'(1);
                  state_q  <= S_RD;
               end
            end
            S_FIN: begin
               done       <= 1'b0;
               span_ready <= 1'b1;
               state_q    <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
`else
   logic unused_zrd;

   assign zrd_en     = 1'b0;
   assign zrd_addr   = '0;
   assign unused_zrd = ^{zrd_valid, zrd_data};

   // Span sequencer without depth test: one write per cycle while wr_ready.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         span_ready  <= 1'b1;
         wr_en       <= 1'b0;
         wr_addr     <= '0;
         wr_color    <= '0;
         wr_z        <= '0;
         done        <= 1'b0;
         pix_written <= '0;
         y_q         <= '0;
         x_q         <= '0;
         xr_q        <= '0;
         zacc_q      <= '0;
         dz_q        <= '0;
         color_q     <= '0;
         addr_q      <= '0;
         cnt_q       <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (span_valid) begin
                  span_ready <= 1'b0;
                  y_q        <= span_y;
                  x_q        <= span_xl;
                  xr_q       <= span_xr;
                  zacc_q     <= span_z0;
                  dz_q       <= span_dz;
                  color_q    <= span_color;
                  state_q    <= S_SETUP;
               end
            end
            S_SETUP: begin
               cnt_q  <= '0;
               addr_q <= start_addr;
               if (span_empty) begin
                  done        <= 1'b1;
                  pix_written <= '0;
                  state_q     <= S_FIN;
               end else begin
                  wr_en    <= 1'b1;
                  wr_addr  <= start_addr;
                  wr_color <= color_q;
                  wr_z     <= znew;
                  state_q  <= S_WR;
               end
            end
            S_WR: begin
               if (wr_ready) begin
                  cnt_q <= cnt_q + 16'd1;
                  if (x_last) begin
                     wr_en       <= 1'b0;
                     done        <= 1'b1;
                     pix_written <= cnt_q + 16'd1;
                     state_q     <= S_FIN;
                  end else begin
                     x_q     <= x_q + 16'd1;
                     addr_q  <= addr_q + ADDR_W'(1);
                     zacc_q  <= zacc_d;
                     wr_addr <= addr_q + ADDR_W'(1);
                     wr_z    <= zacc_d[ZA_W-1:ZF];
                  end
               end
            end
            S_FIN: begin
               done       <= 1'b0;
               span_ready <= 1'b1;
               state_q    <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
`endif

endmodule

// File: doc/scanline_zfill.md
Name: scanline_zfill

Overview:
- Parametrised scanline span filler with per-pixel depth test; successor to the single-line colour fill stage.
- Accepts one span per handshake: row, left/right x, start depth, per-pixel depth slope, colour.
- Walks the span left to right, reads the z-buffer, and writes colour and depth to the frame/z memories where the new pixel is nearer.
- Sits between triangle setup/edge walking and the SRAM arbiter.

Parameters:
- WIDTH, 640, screen width in pixels.
- HEIGHT, 480, screen height in pixels.
- ADDR_W, 19, pixel address width; address = y*WIDTH + x.
- COLOR_W, 8, colour word width.
- Z_W, 8, stored depth width.
- ZF, 8, fractional bits of the depth accumulator.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- span_valid  in  1  span request valid.
- span_ready  out  1  block idle, span accepted when valid && ready.
- span_y  in  16  row, unsigned.
- span_xl  in  16  left x, inclusive, unsigned.
- span_xr  in  16  right x, inclusive, unsigned.
- span_z0  in  Z_W+ZF  depth at span_xl, unsigned fixed point.
- span_dz  in  Z_W+ZF+1  signed depth step per pixel.
- span_color  in  COLOR_W  fill colour.
- zrd_en  out  1  one-cycle z-buffer read strobe.
- zrd_addr  out  ADDR_W  z read address.
- zrd_valid  in  1  read data valid; arbitrary latency, one response per strobe.
- zrd_data  in  Z_W  stored depth.
- wr_en  out  1  colour + depth write request.
- wr_ready  in  1  write accepted when wr_en && wr_ready.
- wr_addr  out  ADDR_W  write address.
- wr_color  out  COLOR_W  colour to write.
- wr_z  out  Z_W  depth to write.
- done  out  1  one-cycle pulse at span completion.
- pix_written  out  16  pixels written in the last span; valid while done is high, held until the next accept.

Behaviour:
- Reset: state IDLE. span_ready=1. zrd_en, wr_en, done=0. zrd_addr, wr_addr, wr_color, wr_z, pix_written=0.
- Reset mid-span aborts immediately: no further writes, and any late zrd_valid is ignored.
- States: IDLE, SETUP, RD, WAIT, TEST, WR, NEXT, FIN.
- IDLE:
  - span_ready=1; on accept, latch all span fields and go to SETUP.
  - span_ready is 0 in every other state.
- SETUP (1 cycle):
  - Clip xr to min(span_xr, WIDTH-1).
  - If span_y>=HEIGHT, or span_xl>clipped xr, go to FIN with 0 writes.
  - Otherwise set addr=y*WIDTH+xl (the only multiply), zacc=span_z0, count=0, and go to RD.
- RD: zrd_en=1 for exactly one cycle with zrd_addr=addr, then go to WAIT.
- WAIT: hold until zrd_valid; capture zrd_data, then go to TEST.
- TEST (compare registered; no write is issued in this cycle):
  - znew = zacc[Z_W+ZF-1:ZF] (integer part, truncate).
  - Pass if znew < stored depth (strict; equal fails).
  - Pass goes to WR; fail goes to NEXT.
- WR:
  - wr_en=1 with wr_addr=addr, wr_color=latched colour, wr_z=znew.
  - Hold all four outputs stable until wr_ready. On accept, count+1 and go to NEXT.
- NEXT:
  - If x==xr go to FIN.
  - Else x+1, addr+1, and zacc+=span_dz with saturation to [0, 2^(Z_W+ZF)-1], then go to RD.
- FIN: done=1 for one cycle, pix_written=count, go to IDLE. span_ready returns the following cycle.
- Per-pixel latency with the test compiled in: 4 cycles + read latency + write stall.
- Addresses never wrap: clipping guarantees addr ≤ HEIGHT*WIDTH-1.
- xl==xr is a 1-pixel span. xl>=WIDTH is an empty span.
- span_valid asserted while busy is ignored; the upstream block holds it until it sees span_ready.

Optional Feature:
- Macro: SCANLINE_ZFILL_ZTEST_EN.
- Defined: full read/compare flow as above.
- Undefined:
  - RD, WAIT and TEST are removed; zrd_en is tied 0 and zrd_valid/zrd_data are unused.
  - Every clipped pixel is written unconditionally at 1 pixel/cycle while wr_ready is high.
  - The state flow is SETUP→WR→(WR…)→FIN: NEXT is merged into the WR accept cycle.
  - pix_written equals the clipped span length.

Test Plan:
1. y=2, xl=10, xr=13, z0=0x0500, dz=+0x0100, colour 0xAB, all stored depths 0xFF, zero-latency reads:
   - 4 writes to addrs 1290..1293 with wr_z 5,6,7,8.
   - pix_written=4, one done pulse.
2. Same span, stored depths {0xFF,0x06,0x07,0x00}:
   - Writes only to addrs 1290 and 1293? No: depth at 1293 is 8 vs 0x00, which fails; equal depths at 1291/1292 also fail.
   - Result: only addr 1290 is written, pix_written=1.
3. xl=630, xr=700, y=0:
   - Clipped to 630..639; last write addr 639.
   - No access at or beyond 640; pix_written=10.
4. Empty and out-of-range spans: xl=20/xr=19, then y=480:
   - No zrd_en and no wr_en.
   - done pulses 2 cycles after each accept with pix_written=0.
5. z0=0xFE80, dz=+0x0100, 3 pixels, stored 0xFF:
   - zacc saturates to 0xFFFF, giving wr_z 0xFE, then 0xFF (fails against stored 0xFF), then 0xFF (fails).
   - One write.
6. wr_ready low for 5 cycles during the first write, then rst pulsed during the third pixel's WAIT:
   - wr_* held stable while stalled.
   - After reset: no wr_en, no done, span_ready=1, and a late zrd_valid is ignored.
